// File: rtl/soc_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// soc_ram_arb_pkg
//   Shared types and helpers for the two-master SoC RAM arbiter.
//   - ram_req_t   : one master request (byte address, write flag, byte
//                   enables, write data)
//   - ram_rsp_t   : one response (read data, error flag)
//   - rsp_state_t : per-master response slot state
//   - addr_hit()  : RAM window decode
// ---------------------------------------------------------------------------
package soc_ram_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ram_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ram_rsp_t;

    typedef enum logic [1:0] {
        RSP_EMPTY,
        RSP_PASS,
        RSP_HOLD
    } rsp_state_t;

    // A request targets the RAM when its masked address equals the window base.
    function automatic logic addr_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/soc_ram_arb_rsp_slot.sv
// ---------------------------------------------------------------------------
// soc_ram_arb_rsp_slot
//   One-entry response slot for a single master. A granted request fills the
//   slot at the end of its grant cycle; the response is then offered on a
//   valid/ready channel until the master accepts it.
//   - Read hits enter PASS: the RAM read data arrives one cycle after the
//     grant and is passed straight through. If the master stalls, the data is
//     captured into the hold register (PASS->HOLD) so it stays stable.
//   - Writes and misses enter HOLD directly with a precomputed response.
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_fill           request granted this cycle; load the slot
//   i_fill_pass      granted request is a read hit (data comes from RAM)
//   i_fill_rsp       response for a write or a miss
//   i_ram_rd_data    RAM read data (valid the cycle after a read grant)
//   i_rsp_ready      master accepts the response
//   o_rsp_valid      response valid
//   o_rsp_rdata      response read data (0 when empty)
//   o_rsp_err        response error flag
//   o_free           slot can take a new request this cycle
// ---------------------------------------------------------------------------
module soc_ram_arb_rsp_slot
    import soc_ram_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fill,
    input  logic        i_fill_pass,
    input  ram_rsp_t    i_fill_rsp,
    input  logic [31:0] i_ram_rd_data,
    input  logic        i_rsp_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_free
);

    rsp_state_t state_reg;
    rsp_state_t state_next;
    ram_rsp_t   hold_reg;
    ram_rsp_t   hold_next;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= RSP_EMPTY;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            RSP_EMPTY: begin
                if (i_fill) begin
                    state_next = i_fill_pass ? RSP_PASS : RSP_HOLD;
                    if (!i_fill_pass) hold_next = i_fill_rsp;
                end
            end
            RSP_PASS: begin
                if (!i_rsp_ready) begin
                    // Master stalled: freeze this cycle's RAM data.
                    state_next = RSP_HOLD;
                    hold_next  = {i_ram_rd_data, 1'b0};
                end else if (i_fill) begin
                    state_next = i_fill_pass ? RSP_PASS : RSP_HOLD;
                    if (!i_fill_pass) hold_next = i_fill_rsp;
                end else begin
                    state_next = RSP_EMPTY;
                end
            end
            RSP_HOLD: begin
                if (i_rsp_ready) begin
                    if (i_fill) begin
                        state_next = i_fill_pass ? RSP_PASS : RSP_HOLD;
                        if (!i_fill_pass) hold_next = i_fill_rsp;
                    end else begin
                        state_next = RSP_EMPTY;
                    end
                end
            end
            default: state_next = RSP_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = 1'b0;
        case (state_reg)
            RSP_PASS: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = i_ram_rd_data;
            end
            RSP_HOLD: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = hold_reg.rdata;
                o_rsp_err   = hold_reg.err;
            end
            default: ;
        endcase
        // A full slot frees up in the same cycle its response is accepted.
        o_free = (state_reg == RSP_EMPTY) || i_rsp_ready;
    end

endmodule

// File: rtl/soc_ram_arbiter.sv
// ---------------------------------------------------------------------------
// soc_ram_arbiter
//   Two-master arbiter in front of the single-port 32-bit SoC RAM.
//   m0 = instruction fetch, m1 = data load/store. At most one request is
//   granted per cycle; a granted hit drives the RAM in the same cycle, a
//   granted miss produces an error response without touching the RAM.
//   Responses return one cycle after the grant through a per-master slot.
// Configuration
//   SOC_RAM_ARB_RR_EN defined   : round-robin on conflicts (the master not
//                                 granted last wins; pointer moves on grant)
//   SOC_RAM_ARB_RR_EN undefined : fixed priority m1 > m0
// Parameters
//   p_addr_base / p_addr_mask   RAM window decode
//   p_err_rdata                 read data returned with an error response
// Ports
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_m{0,1}_req_valid/o_..._req_ready request handshake (ready = grant)
//   i_m{0,1}_addr/we/be/wdata         request payload
//   o_m{0,1}_rsp_valid/i_..._rsp_ready response handshake
//   o_m{0,1}_rsp_rdata/rsp_err        response payload
//   o_ram_addr/be/wr_en/wr_data/rd_en RAM port (word address)
//   i_ram_rd_data                     RAM read data, one cycle after rd_en
//   i_ram_busy                        RAM busy; blocks all grants
// ---------------------------------------------------------------------------
module soc_ram_arbiter
    import soc_ram_arb_pkg::*;
#(
    parameter logic [31:0] p_addr_base = 32'h10000000,
    parameter logic [31:0] p_addr_mask = 32'hfffff000,
    parameter logic [31:0] p_err_rdata = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_req_valid,
    output logic        o_m0_req_ready,
    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_be,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_rsp_valid,
    input  logic        i_m0_rsp_ready,
    output logic [31:0] o_m0_rsp_rdata,
    output logic        o_m0_rsp_err,

    input  logic        i_m1_req_valid,
    output logic        o_m1_req_ready,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_be,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_rsp_valid,
    input  logic        i_m1_rsp_ready,
    output logic [31:0] o_m1_rsp_rdata,
    output logic        o_m1_rsp_err,

    output logic [29:0] o_ram_addr,
    output logic [3:0]  o_ram_be,
    output logic        o_ram_wr_en,
    output logic [31:0] o_ram_wr_data,
    output logic        o_ram_rd_en,
    input  logic [31:0] i_ram_rd_data,
    input  logic        i_ram_busy
);

    ram_req_t                 req [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   req_valid;
    logic [NUM_MASTERS-1:0]   rsp_ready;
    logic [NUM_MASTERS-1:0]   hit;
    logic [NUM_MASTERS-1:0]   slot_free;
    logic [NUM_MASTERS-1:0]   eligible;
    logic [NUM_MASTERS-1:0]   grant;
    logic [NUM_MASTERS-1:0]   rsp_valid;
    logic [NUM_MASTERS-1:0]   rsp_err;
    logic [31:0]              rsp_rdata [NUM_MASTERS];
    ram_req_t                 sel_req;
    logic                     sel_hit;

    assign req[0]       = {i_m0_addr, i_m0_we, i_m0_be, i_m0_wdata};
    assign req[1]       = {i_m1_addr, i_m1_we, i_m1_be, i_m1_wdata};
    assign req_valid    = {i_m1_req_valid, i_m0_req_valid};
    assign rsp_ready    = {i_m1_rsp_ready, i_m0_rsp_ready};

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        logic     read_hit;
        ram_rsp_t fill_rsp;

        assign hit[gi]      = addr_hit(req[gi].addr, p_addr_base, p_addr_mask);
        // Gating with reset keeps req_ready and RAM enables low during reset.
        assign eligible[gi] = i_rst_n & req_valid[gi] & ~i_ram_busy & slot_free[gi];
        assign read_hit     = hit[gi] & ~req[gi].we;
        assign fill_rsp     = hit[gi] ? ram_rsp_t'('0) : ram_rsp_t'({p_err_rdata, 1'b1});

        soc_ram_arb_rsp_slot u_slot (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_fill        (grant[gi]),
            .i_fill_pass   (read_hit),
            .i_fill_rsp    (fill_rsp),
            .i_ram_rd_data (i_ram_rd_data),
            .i_rsp_ready   (rsp_ready[gi]),
            .o_rsp_valid   (rsp_valid[gi]),
            .o_rsp_rdata   (rsp_rdata[gi]),
            .o_rsp_err     (rsp_err[gi]),
            .o_free        (slot_free[gi])
        );
    end

`ifdef SOC_RAM_ARB_RR_EN
    // Index of the master granted most recently. Resetting to m0 makes m1
    // the winner of the first conflict.
    logic last_grant_reg;
    logic last_grant_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last_grant_reg <= 1'b0;
        else          last_grant_reg <= last_grant_next;
    end

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
        last_grant_next = last_grant_reg;
        if (grant[1])      last_grant_next = 1'b1;
        else if (grant[0]) last_grant_next = 1'b0;
    end
`else
    // Fixed priority: m1 always wins a conflict.
    always_comb begin
        grant = eligible;
        if (eligible[1]) grant[0] = 1'b0;
    end
`endif

    // RAM port: payload follows the granted master; enables only on a hit.
    always_comb begin
        sel_req       = grant[1] ? req[1] : req[0];
        sel_hit       = |(grant & hit);
        o_ram_addr    = sel_req.addr[31:2];
        o_ram_be      = sel_req.be;
        o_ram_wr_data = sel_req.wdata;
        o_ram_wr_en   = sel_hit & sel_req.we;
        o_ram_rd_en   = sel_hit & ~sel_req.we;
    end

    assign o_m0_req_ready = grant[0];
    assign o_m1_req_ready = grant[1];
    assign o_m0_rsp_valid = rsp_valid[0];
    assign o_m1_rsp_valid = rsp_valid[1];
    assign o_m0_rsp_rdata = rsp_rdata[0];
    assign o_m1_rsp_rdata = rsp_rdata[1];
    assign o_m0_rsp_err   = rsp_err[0];
    assign o_m1_rsp_err   = rsp_err[1];

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_ram_arbiter
//   Bench for soc_ram_arbiter with a behavioural RAM (registered read,
//   byte-enabled write) and a reference model for the randomized run.
// ---------------------------------------------------------------------------
module tb_soc_ram_arbiter;

    localparam logic [31:0] P_ERR = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic [1:0]  rsp_ready = 2'b11;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata [2];
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data = '0;
    logic        ram_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_ram_arbiter #(
        .p_addr_base (32'h10000000),
        .p_addr_mask (32'hfffff000),
        .p_err_rdata (P_ERR)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_m0_req_valid (req_valid[0]),
        .o_m0_req_ready (req_ready[0]),
        .i_m0_addr      (addr[0]),
        .i_m0_we        (we[0]),
        .i_m0_be        (be[0]),
        .i_m0_wdata     (wdata[0]),
        .o_m0_rsp_valid (rsp_valid[0]),
        .i_m0_rsp_ready (rsp_ready[0]),
        .o_m0_rsp_rdata (rsp_rdata[0]),
        .o_m0_rsp_err   (rsp_err[0]),
        .i_m1_req_valid (req_valid[1]),
        .o_m1_req_ready (req_ready[1]),
        .i_m1_addr      (addr[1]),
        .i_m1_we        (we[1]),
        .i_m1_be        (be[1]),
        .i_m1_wdata     (wdata[1]),
        .o_m1_rsp_valid (rsp_valid[1]),
        .i_m1_rsp_ready (rsp_ready[1]),
        .o_m1_rsp_rdata (rsp_rdata[1]),
        .o_m1_rsp_err   (rsp_err[1]),
        .o_ram_addr     (ram_addr),
        .o_ram_be       (ram_be),
        .o_ram_wr_en    (ram_wr_en),
        .o_ram_wr_data  (ram_wr_data),
        .o_ram_rd_en    (ram_rd_en),
        .i_ram_rd_data  (ram_rd_data),
        .i_ram_busy     (ram_busy)
    );

    // Behavioural single-port RAM covering the 4 KiB window.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[9:0]][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_addr[9:0]];
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_reqs();
        req_valid = '0;
        we        = '0;
        for (int m = 0; m < 2; m++) begin
            addr[m]  = '0;
            be[m]    = '0;
            wdata[m] = '0;
        end
    endtask

    task automatic drive_req(input int m, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
        req_valid[m] = 1'b1;
        we[m]        = w;
        addr[m]      = a;
        be[m]        = b;
        wdata[m]     = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_reqs();
        rsp_ready = 2'b11;
        ram_busy  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_req(0, 1'b0, 32'h10000000, 4'h0, 32'h0);
        drive_req(1, 1'b1, 32'h10000004, 4'hF, 32'h11111111);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++;
        if ({ram_wr_en, ram_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_ram_en: got %b expected 00", {ram_wr_en, ram_rd_en}); end
        checks++;
        if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin errors++; $display("FAIL reset_rsp: got valid=%b err=%b expected 00/00", rsp_valid, rsp_err); end
        checks++;
        if (rsp_rdata[0] !== 32'h0 || rsp_rdata[1] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0", rsp_rdata[0], rsp_rdata[1]); end
        $display("reset: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
        apply_reset();
    endtask

    task automatic test_write_read();
        apply_reset();
        next_cycle();
        drive_req(1, 1'b1, 32'h10000010, 4'hF, 32'hCAFEBABE);
        @(negedge clk);
        $display("m1 write 10000010 <= cafebabe: ready=%b", req_ready);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b expected 10", req_ready); end
        checks++;
        if ({ram_wr_en, ram_rd_en} !== 2'b10 || ram_addr !== 30'h04000004 || ram_wr_data !== 32'hCAFEBABE)
            begin errors++; $display("FAIL wr_ram: got en=%b addr=%h data=%h expected 10/04000004/cafebabe", {ram_wr_en, ram_rd_en}, ram_addr, ram_wr_data); end
        next_cycle();
        drive_req(1, 1'b0, 32'h10000010, 4'h0, 32'h0);
        @(negedge clk);
        $display("m1 read 10000010: ready=%b wr_rsp valid=%b", req_ready, rsp_valid[1]);
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0)
            begin errors++; $display("FAIL wr_rsp: got v=%b d=%h e=%b expected 1/0/0", rsp_valid[1], rsp_rdata[1], rsp_err[1]); end
        checks++;
        if (req_ready !== 2'b10 || ram_rd_en !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b rd_en=%b expected 10/1", req_ready, ram_rd_en); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        $display("m1 read rsp: valid=%b data=%h", rsp_valid[1], rsp_rdata[1]);
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEBABE || rsp_err[1] !== 1'b0)
            begin errors++; $display("FAIL rd_rsp: got v=%b d=%h e=%b expected 1/cafebabe/0", rsp_valid[1], rsp_rdata[1], rsp_err[1]); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_drain: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_conflict();
        logic [1:0] exp_g;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_req(0, 1'b0, 32'h10000040, 4'h0, 32'h0);
            drive_req(1, 1'b0, 32'h10000044, 4'h0, 32'h0);
            @(negedge clk);
`ifdef SOC_RAM_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            $display("conflict %0d: ready=%b", k, req_ready);
            checks++;
            if (req_ready !== exp_g) begin errors++; $display("FAIL conflict_%0d: got %b expected %b", k, req_ready, exp_g); end
        end
        next_cycle();
        req_valid[1] = 1'b0;
        @(negedge clk);
        $display("m0 alone: ready=%b", req_ready);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL conflict_m0_next: got %b expected 01", req_ready); end
        next_cycle();
        clear_reqs();
    endtask

    task automatic test_hold();
        apply_reset();
        next_cycle();
        drive_req(1, 1'b1, 32'h10000020, 4'hF, 32'h12345678);
        next_cycle();
        drive_req(1, 1'b1, 32'h10000024, 4'hF, 32'h9ABCDEF0);
        next_cycle();
        clear_reqs();
        apply_reset();                     // RAM contents survive reset
        next_cycle();
        rsp_ready = 2'b10;
        drive_req(0, 1'b0, 32'h10000020, 4'h0, 32'h0);
        drive_req(1, 1'b0, 32'h10000024, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_first: got %b expected 10", req_ready); end
        next_cycle();
        req_valid[1] = 1'b0;
        @(negedge clk);
        $display("m0 read 10000020 granted: ready=%b m1 data=%h", req_ready, rsp_rdata[1]);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_m0_grant: got %b expected 01", req_ready); end
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h9ABCDEF0) begin errors++; $display("FAIL hold_m1_rsp: got v=%b d=%h expected 1/9abcdef0", rsp_valid[1], rsp_rdata[1]); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req_valid[1] = 1'b1;           // keeps the RAM read port busy with other data
            @(negedge clk);
            $display("stall %0d: m0 v=%b d=%h ready=%b", k, rsp_valid[0], rsp_rdata[0], req_ready);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h12345678 || req_ready[0] !== 1'b0)
                begin errors++; $display("FAIL hold_stall_%0d: got v=%b d=%h rdy=%b expected 1/12345678/0", k, rsp_valid[0], rsp_rdata[0], req_ready[0]); end
        end
        next_cycle();
        req_valid[1] = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h12345678 || req_ready[0] !== 1'b1)
            begin errors++; $display("FAIL hold_accept: got v=%b d=%h rdy=%b expected 1/12345678/1", rsp_valid[0], rsp_rdata[0], req_ready[0]); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h12345678) begin errors++; $display("FAIL hold_reread: got v=%b d=%h expected 1/12345678", rsp_valid[0], rsp_rdata[0]); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL hold_drain: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_miss();
        apply_reset();
        next_cycle();
        drive_req(1, 1'b0, 32'h20000000, 4'h0, 32'h0);
        @(negedge clk);
        $display("m1 read 20000000 (miss): ready=%b", req_ready);
        checks++;
        if (req_ready !== 2'b10 || {ram_wr_en, ram_rd_en} !== 2'b00) begin errors++; $display("FAIL miss_rd_ram: got rdy=%b en=%b expected 10/00", req_ready, {ram_wr_en, ram_rd_en}); end
        next_cycle();
        clear_reqs();
        drive_req(0, 1'b1, 32'h10001000, 4'hF, 32'h55555555);   // just past the window
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || {ram_wr_en, ram_rd_en} !== 2'b00) begin errors++; $display("FAIL miss_wr_ram: got rdy=%b en=%b expected 01/00", req_ready, {ram_wr_en, ram_rd_en}); end
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b1 || rsp_rdata[1] !== P_ERR) begin errors++; $display("FAIL miss_rd_rsp: got v=%b e=%b d=%h expected 1/1/%h", rsp_valid[1], rsp_err[1], rsp_rdata[1], P_ERR); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_rdata[0] !== P_ERR) begin errors++; $display("FAIL miss_wr_rsp: got v=%b e=%b d=%h expected 1/1/%h", rsp_valid[0], rsp_err[0], rsp_rdata[0], P_ERR); end
    endtask

    task automatic test_byte_enable();
        apply_reset();
        next_cycle();
        drive_req(0, 1'b1, 32'h10000030, 4'hF, 32'h00000000);
        next_cycle();
        drive_req(0, 1'b1, 32'h10000030, 4'b0101, 32'hAABBCCDD);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || ram_be !== 4'b0101 || ram_wr_en !== 1'b1) begin errors++; $display("FAIL be_write: got rdy=%b be=%b wr=%b expected 01/0101/1", req_ready, ram_be, ram_wr_en); end
        next_cycle();
        drive_req(0, 1'b0, 32'h10000030, 4'h0, 32'h0);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        $display("m0 read 10000030 after be=0101: data=%h", rsp_rdata[0]);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h00BB00DD) begin errors++; $display("FAIL be_readback: got v=%b d=%h expected 1/00bb00dd", rsp_valid[0], rsp_rdata[0]); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        rsp_ready = 2'b00;
        next_cycle();
        drive_req(1, 1'b0, 32'h10000010, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL areset_grant: got %b expected 10", req_ready); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL areset_pending: got %b expected 1", rsp_valid[1]); end
        #2;
        rst_n = 1'b0;
        drive_req(1, 1'b0, 32'h10000010, 4'h0, 32'h0);
        #1;
        $display("async reset mid-cycle: rsp_valid=%b ready=%b", rsp_valid, req_ready);
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || ram_rd_en !== 1'b0)
            begin errors++; $display("FAIL areset_drop: got v=%b rdy=%b rd=%b expected 00/00/0", rsp_valid, req_ready, ram_rd_en); end
        clear_reqs();
        rsp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive_req(1, 1'b0, 32'h10000010, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL areset_after_grant: got %b expected 10", req_ready); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEBABE) begin errors++; $display("FAIL areset_after_rsp: got v=%b d=%h expected 1/cafebabe", rsp_valid[1], rsp_rdata[1]); end
    endtask

    // Random traffic against a transaction-level model: a shadow copy of the
    // RAM window plus one outstanding expected response per master.
    task automatic test_random();
        logic [31:0] shadow [16];
        bit          pend [2];
        logic [31:0] exp_rd [2];
        logic        exp_er [2];
        logic [1:0]  elig;
        logic [1:0]  exp_g;
        int          gm;
        bit          ghit;
        int          w;
`ifdef SOC_RAM_ARB_RR_EN
        int          rr_last = 0;
`endif
        apply_reset();
        for (int m = 0; m < 2; m++) pend[m] = 0;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            clear_reqs();
            if (i < 16) begin
                drive_req(0, 1'b1, 32'h10000000 | (i << 2), 4'hF, $urandom);
                rsp_ready = 2'b11;
                ram_busy  = 1'b0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    req_valid[m] = ($urandom_range(0, 3) != 0);
                    we[m]        = 1'($urandom_range(0, 1));
                    w            = $urandom_range(0, 15);
                    if ($urandom_range(0, 9) == 0) addr[m] = 32'h30000000 | (w << 2);
                    else addr[m] = 32'h10000000 | (w << 2) | $urandom_range(0, 3);
                    be[m]        = 4'($urandom);
                    wdata[m]     = $urandom;
                    rsp_ready[m] = ($urandom_range(0, 3) != 0);
                end
                ram_busy = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            for (int m = 0; m < 2; m++)
                elig[m] = req_valid[m] && !ram_busy && (!pend[m] || rsp_ready[m]);
`ifdef SOC_RAM_ARB_RR_EN
            if (elig == 2'b11) exp_g = (rr_last == 1) ? 2'b01 : 2'b10;
            else exp_g = elig;
`else
            exp_g = elig[1] ? 2'b10 : elig;
`endif
            checks++;
            if (req_ready !== exp_g) begin errors++; $display("FAIL rnd_grant @%0d: got %b expected %b", i, req_ready, exp_g); end
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rsp_valid[m] !== pend[m] || (pend[m] && (rsp_rdata[m] !== exp_rd[m] || rsp_err[m] !== exp_er[m])))
                    begin errors++; $display("FAIL rnd_rsp%0d @%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b", m, i, rsp_valid[m], rsp_rdata[m], rsp_err[m], pend[m], exp_rd[m], exp_er[m]); end
            end
            gm   = exp_g[1] ? 1 : 0;
            ghit = (exp_g != 2'b00) && (addr[gm][31:12] == 20'h10000);
            checks++;
            if (ram_rd_en !== (ghit && !we[gm]) || ram_wr_en !== (ghit && we[gm]) || (ghit && ram_addr !== addr[gm][31:2]))
                begin errors++; $display("FAIL rnd_ram @%0d: got rd=%b wr=%b addr=%h", i, ram_rd_en, ram_wr_en, ram_addr); end
            // Model update for the coming edge.
            for (int m = 0; m < 2; m++) if (pend[m] && rsp_ready[m]) pend[m] = 0;
            if (exp_g != 2'b00) begin
                w = int'(addr[gm][5:2]);
                if (!ghit) begin
                    exp_rd[gm] = P_ERR; exp_er[gm] = 1'b1;
                end else if (we[gm]) begin
                    for (int b = 0; b < 4; b++) if (be[gm][b]) shadow[w][b*8 +: 8] = wdata[gm][b*8 +: 8];
                    exp_rd[gm] = 32'h0; exp_er[gm] = 1'b0;
                end else begin
                    exp_rd[gm] = shadow[w]; exp_er[gm] = 1'b0;
                end
                pend[gm] = 1;
`ifdef SOC_RAM_ARB_RR_EN
                rr_last = gm;
`endif
                $display("rnd %0d: m%0d %s %h hit=%0d", i, gm, we[gm] ? "wr" : "rd", addr[gm], ghit);
            end
        end
        clear_reqs();
        rsp_ready = 2'b11;
        ram_busy  = 1'b0;
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_write_read();
        test_conflict();
        test_hold();
        test_miss();
        test_byte_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
